// File: rtl/trn_axi_share_regfile.sv
// trn_axi_share_regfile
// AXI4-Lite slave register file shared between the PS (over AXI) and PL logic
// (over a fabric write port). NUM_REGS registers of DATA_WIDTH bits, write
// strobes honoured, out-of-range accesses answered with SLVERR.
//
// Ports:
//   ACLK, ARESET         clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*      AXI4-Lite write address / data / response channels
//   S_AXI_AR*/R*         AXI4-Lite read address / data channels
//   hw_wr_en/idx/data    fabric full-word write port
//   hw_wr_drop           1-cycle pulse when a fabric write loses to an AXI write
//   reg_out              flat register image, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse         per-register update pulse (only with TRN_SHARE_WR_PULSE_EN)
//
// Optional feature macro: TRN_SHARE_WR_PULSE_EN

module trn_axi_share_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                                          ACLK,
    input  logic                                          ARESET,
    input  logic [ADDR_WIDTH-1:0]                         S_AXI_AWADDR,
    input  logic [2:0]                                    S_AXI_AWPROT,
    input  logic                                          S_AXI_AWVALID,
    output logic                                          S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                         S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                       S_AXI_WSTRB,
    input  logic                                          S_AXI_WVALID,
    output logic                                          S_AXI_WREADY,
    output logic [1:0]                                    S_AXI_BRESP,
    output logic                                          S_AXI_BVALID,
    input  logic                                          S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                         S_AXI_ARADDR,
    input  logic [2:0]                                    S_AXI_ARPROT,
    input  logic                                          S_AXI_ARVALID,
    output logic                                          S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                         S_AXI_RDATA,
    output logic [1:0]                                    S_AXI_RRESP,
    output logic                                          S_AXI_RVALID,
    input  logic                                          S_AXI_RREADY,
    input  logic                                          hw_wr_en,
    input  logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] hw_wr_idx,
    input  logic [DATA_WIDTH-1:0]                         hw_wr_data,
    output logic                                          hw_wr_drop,
    output logic [NUM_REGS*DATA_WIDTH-1:0]                reg_out
`ifdef TRN_SHARE_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]                           reg_wr_pulse
`endif
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned AIDX_W   = ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t                  w_state, w_state_d;
    r_state_t                  r_state, r_state_d;

    logic                      aw_held, aw_held_d;
    logic                      w_held, w_held_d;
    logic [AIDX_W-1:0]         aw_idx, aw_idx_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic                      awready_d, wready_d, bvalid_d;
    logic [1:0]                bresp_d;
    logic                      axi_wr_c;
    logic                      aw_in_range_c;

    logic                      arready_d, rvalid_d;
    logic [DATA_WIDTH-1:0]     rdata_d;
    logic [1:0]                rresp_d;
    logic [AIDX_W-1:0]         ar_idx_c;
    logic                      ar_in_range_c;
    logic [DATA_WIDTH-1:0]     rd_word_c;

    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]       pulse_d;
    logic                      hw_ok_c;
    logic                      collide_c;

    assign aw_in_range_c = 32'(aw_idx) < NUM_REGS;
    assign ar_idx_c      = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign ar_in_range_c = 32'(ar_idx_c) < NUM_REGS;
    assign hw_ok_c       = hw_wr_en && (32'(hw_wr_idx) < NUM_REGS);
    assign collide_c     = axi_wr_c && hw_ok_c && (32'(aw_idx) == 32'(hw_wr_idx));
    assign reg_out       = regs_q;

    // Write FSM: next state
    always_comb begin
        w_state_d = w_state;
        case (w_state)
            W_IDLE:  if (aw_held && w_held) w_state_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY)      w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM: channel latches and next values of the registered outputs
    always_comb begin
        aw_held_d = aw_held;
        w_held_d  = w_held;
        aw_idx_d  = aw_idx;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = S_AXI_AWREADY;
        wready_d  = S_AXI_WREADY;
        bvalid_d  = S_AXI_BVALID;
        bresp_d   = S_AXI_BRESP;
        axi_wr_c  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_held && w_held) begin
                    bvalid_d = 1'b1;
                    bresp_d  = aw_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    axi_wr_c = aw_in_range_c;
                end else begin
                    // AW and W are captured independently; ready stays low once held
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        aw_held_d = 1'b1;
                        awready_d = 1'b0;
                        aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                    end else if (!aw_held) begin
                        awready_d = 1'b1;
                    end
                    if (S_AXI_WVALID && S_AXI_WREADY) begin
                        w_held_d = 1'b1;
                        wready_d = 1'b0;
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
                    end else if (!w_held) begin
                        wready_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Read FSM: next state
    always_comb begin
        r_state_d = r_state;
        case (r_state)
            R_IDLE:  if (S_AXI_ARVALID && S_AXI_ARREADY) r_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY)                   r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read mux: out-of-range indices fall through to zero
    always_comb begin
        rd_word_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(ar_idx_c) == i) rd_word_c = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Read FSM: next values of the registered outputs
    always_comb begin
        arready_d = S_AXI_ARREADY;
        rvalid_d  = S_AXI_RVALID;
        rdata_d   = S_AXI_RDATA;
        rresp_d   = S_AXI_RRESP;
        case (r_state)
            R_IDLE: begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word_c;
                    rresp_d   = ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Register update: AXI has priority over the fabric port on the same index
    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (axi_wr_c && (32'(aw_idx) == i)) begin
                for (int unsigned k = 0; k < STRB_W; k++) begin
                    if (wstrb_q[k]) regs_d[i*DATA_WIDTH + 8*k +: 8] = wdata_q[8*k +: 8];
                end
                pulse_d[i] = 1'b1;
            end else if (hw_ok_c && (32'(hw_wr_idx) == i)) begin
                regs_d[i*DATA_WIDTH +: DATA_WIDTH] = hw_wr_data;
                pulse_d[i] = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_d;
            r_state <= r_state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            regs_q        <= '0;
            hw_wr_drop    <= 1'b0;
        end else begin
            aw_held       <= aw_held_d;
            w_held        <= w_held_d;
            aw_idx        <= aw_idx_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            S_AXI_AWREADY <= awready_d;
            S_AXI_WREADY  <= wready_d;
            S_AXI_BVALID  <= bvalid_d;
            S_AXI_BRESP   <= bresp_d;
            S_AXI_ARREADY <= arready_d;
            S_AXI_RVALID  <= rvalid_d;
            S_AXI_RDATA   <= rdata_d;
            S_AXI_RRESP   <= rresp_d;
            regs_q        <= regs_d;
            hw_wr_drop    <= collide_c;
        end
    end

`ifdef TRN_SHARE_WR_PULSE_EN
    // Per-register commit pulse
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) reg_wr_pulse <= '0;
        else        reg_wr_pulse <= pulse_d;
    end
`endif

    // PROT and the sub-word address bits carry no meaning here
    logic unused_c;
    assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]
`ifndef TRN_SHARE_WR_PULSE_EN
                        , pulse_d
`endif
                       };

endmodule
